// File: rtl/writeback_unit.sv
// writeback_unit
// Final pipeline stage between the memory stage and the register file.
// Picks the register-file write value (ALU result, extracted load data or
// PC+4), performs byte/half/word/double load extraction with sign or zero
// extension, and waits for late load responses in a single WAIT_MEM state.
// Writes to x0 are dropped, and misaligned or illegal loads raise a one-cycle
// error pulse. A combinational bypass shows the write that commits at the next
// edge, and a free-running counter tracks retired instructions.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   valid_i/ready_o upstream handshake (ready_o low while waiting for memory)
//   sel_rd_i, rd_we_i, wb_src_i, load_funct3_i, addr_off_i   instruction fields
//   alu_result_i, pc_plus4_i                                 candidate values
//   mem_rvalid_i, mem_rdata_i                                load response
//   bypass_valid_o, bypass_rd_o, bypass_data_o               same-cycle forward
//   sel_rd_o, we_o, data_o                                   registered write port
//   err_o                                                    misaligned/illegal load pulse
//   retired_o                                                completed-instruction count
module writeback_unit #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = $clog2(NUM_REGS),
    parameter int OFF_W    = $clog2(XLEN / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [REG_AW-1:0] sel_rd_i,
    input  logic              rd_we_i,
    input  logic [1:0]        wb_src_i,
    input  logic [2:0]        load_funct3_i,
    input  logic [OFF_W-1:0]  addr_off_i,
    input  logic [XLEN-1:0]   alu_result_i,
    input  logic [XLEN-1:0]   pc_plus4_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic              bypass_valid_o,
    output logic [REG_AW-1:0] bypass_rd_o,
    output logic [XLEN-1:0]   bypass_data_o,
    output logic [REG_AW-1:0] sel_rd_o,
    output logic              we_o,
    output logic [XLEN-1:0]   data_o,
    output logic              err_o,
    output logic [31:0]       retired_o
);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t              state, next_state;
    logic [REG_AW-1:0]   pend_rd;
    logic                pend_we;
    logic [2:0]          pend_f3;
    logic [OFF_W-1:0]    pend_off;

    logic                complete;
    logic                cur_is_load;
    logic [REG_AW-1:0]   cur_rd;
    logic                cur_we;
    logic [2:0]          cur_f3;
    logic [OFF_W-1:0]    cur_off;
    logic [XLEN-1:0]     shifted;
    logic [XLEN-1:0]     load_val;
    logic                load_err;
    logic [XLEN-1:0]     wb_val;
    logic                cur_err;
    logic                write;

    // State register; reset also drops any load still waiting for data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // A load that does not see its response in the accept cycle parks in
    // WAIT_MEM until the memory answers.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (valid_i && wb_src_i == 2'd1 && !mem_rvalid_i) next_state = WAIT_MEM;
            WAIT_MEM: if (mem_rvalid_i) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Handshake output and the choice between live and parked fields.
    always_comb begin
        ready_o     = (state == IDLE);
        cur_rd      = sel_rd_i;
        cur_we      = rd_we_i;
        cur_f3      = load_funct3_i;
        cur_off     = addr_off_i;
        cur_is_load = (wb_src_i == 2'd1);
        complete    = valid_i && (wb_src_i != 2'd1 || mem_rvalid_i);
        if (state == WAIT_MEM) begin
            cur_rd      = pend_rd;
            cur_we      = pend_we;
            cur_f3      = pend_f3;
            cur_off     = pend_off;
            cur_is_load = 1'b1;
            complete    = mem_rvalid_i;
        end
    end

    // Load extraction. The addressed bytes are shifted down to bit 0 first.
    // Each access size is then checked for natural alignment.
    always_comb begin
        shifted  = mem_rdata_i >> {cur_off, 3'b000};
        load_val = '0;
        load_err = 1'b0;
        case (cur_f3)
            3'd0: load_val = XLEN'($signed(shifted[7:0]));
            3'd4: load_val = XLEN'(shifted[7:0]);
            3'd1: begin
                load_val = XLEN'($signed(shifted[15:0]));
                load_err = cur_off[0];
            end
            3'd5: begin
                load_val = XLEN'(shifted[15:0]);
                load_err = cur_off[0];
            end
            3'd2: begin
                load_val = XLEN'($signed(shifted[31:0]));
                load_err = (cur_off[1:0] != 2'd0);
            end
            3'd6: begin
                load_val = XLEN'(shifted[31:0]);
                load_err = (XLEN == 32) || (cur_off[1:0] != 2'd0);
            end
            3'd3: begin
                load_val = shifted;
                load_err = (XLEN == 32) || (cur_off != '0);
            end
            default: load_err = 1'b1;
        endcase
    end

    // Commit decision. Errors and x0 targets still retire but never write.
    always_comb begin
        if (cur_is_load)             wb_val = load_val;
        else if (wb_src_i == 2'd2)   wb_val = pc_plus4_i;
        else                         wb_val = alu_result_i;
        cur_err        = cur_is_load && load_err;
        write          = complete && cur_we && (cur_rd != '0) && !cur_err;
        bypass_valid_o = write;
        bypass_rd_o    = cur_rd;
        bypass_data_o  = wb_val;
    end

    // Capture the fields of a load whose data has not arrived yet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_rd  <= '0;
            pend_we  <= 1'b0;
            pend_f3  <= 3'd0;
            pend_off <= '0;
        end else if (state == IDLE && next_state == WAIT_MEM) begin
            pend_rd  <= sel_rd_i;
            pend_we  <= rd_we_i;
            pend_f3  <= load_funct3_i;
            pend_off <= addr_off_i;
        end
    end

    // Registered write port. The register-file address and data keep the
    // last committed values when nothing is written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_rd_o  <= '0;
            we_o      <= 1'b0;
            data_o    <= '0;
            err_o     <= 1'b0;
            retired_o <= 32'd0;
        end else begin
            we_o  <= write;
            err_o <= complete && cur_err;
            if (write) begin
                sel_rd_o <= cur_rd;
                data_o   <= wb_val;
            end
            if (complete) retired_o <= retired_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit
// Directed and random stimulus for writeback_unit. The XLEN=32 instance is
// checked every cycle against a behavioural model of the handshake and the
// load rules. A second XLEN=64 instance covers the double-word loads.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst;

    logic        valid_i, ready_o, rd_we_i, mem_rvalid_i;
    logic [4:0]  sel_rd_i, bypass_rd_o, sel_rd_o;
    logic [1:0]  wb_src_i, addr_off_i;
    logic [2:0]  load_funct3_i;
    logic [31:0] alu_result_i, pc_plus4_i, mem_rdata_i, bypass_data_o, data_o, retired_o;
    logic        bypass_valid_o, we_o, err_o;

    logic        d64_valid, d64_ready, d64_rd_we, d64_rvalid;
    logic [4:0]  d64_sel_rd, d64_byp_rd, d64_sel_rd_o;
    logic [1:0]  d64_wb_src;
    logic [2:0]  d64_f3, d64_off;
    logic [63:0] d64_alu, d64_pc, d64_rdata, d64_byp_data, d64_data_o;
    logic        d64_byp_valid, d64_we_o, d64_err_o;
    logic [31:0] d64_retired;

    int          errors = 0;
    int          checks = 0;

    // Reference model state for the XLEN=32 instance
    bit          m_busy;
    logic [4:0]  m_rd;
    bit          m_we;
    logic [2:0]  m_f3;
    logic [1:0]  m_off;
    logic        e_we, e_err;
    logic [4:0]  e_rd;
    logic [31:0] e_data, e_ret;
    logic [63:0] e64_data;
    logic [31:0] e64_ret;

    always #5 clk = ~clk;

    writeback_unit #(.XLEN(32), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .sel_rd_i(sel_rd_i), .rd_we_i(rd_we_i), .wb_src_i(wb_src_i),
        .load_funct3_i(load_funct3_i), .addr_off_i(addr_off_i),
        .alu_result_i(alu_result_i), .pc_plus4_i(pc_plus4_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .bypass_valid_o(bypass_valid_o), .bypass_rd_o(bypass_rd_o),
        .bypass_data_o(bypass_data_o), .sel_rd_o(sel_rd_o), .we_o(we_o),
        .data_o(data_o), .err_o(err_o), .retired_o(retired_o)
    );

    writeback_unit #(.XLEN(64), .NUM_REGS(32)) dut64 (
        .clk(clk), .rst(rst), .valid_i(d64_valid), .ready_o(d64_ready),
        .sel_rd_i(d64_sel_rd), .rd_we_i(d64_rd_we), .wb_src_i(d64_wb_src),
        .load_funct3_i(d64_f3), .addr_off_i(d64_off),
        .alu_result_i(d64_alu), .pc_plus4_i(d64_pc),
        .mem_rvalid_i(d64_rvalid), .mem_rdata_i(d64_rdata),
        .bypass_valid_o(d64_byp_valid), .bypass_rd_o(d64_byp_rd),
        .bypass_data_o(d64_byp_data), .sel_rd_o(d64_sel_rd_o), .we_o(d64_we_o),
        .data_o(d64_data_o), .err_o(d64_err_o), .retired_o(d64_retired)
    );

    // Load result from first principles: take the access-sized field at the
    // byte offset, and subtract 2^bits when a signed value has its top bit set.
    function automatic logic [63:0] refLoad(input int xlen, input logic [2:0] f3,
                                            input int off, input logic [63:0] rdata,
                                            output bit err);
        int           size;
        logic [127:0] m, v;
        size = 1 << f3[1:0];
        err  = (f3 == 3'd7) || (xlen == 32 && (f3 == 3'd3 || f3 == 3'd6)) || (off % size != 0);
        m    = 128'd1 << (8 * size);
        v    = ({64'd0, rdata} >> (8 * off)) & (m - 128'd1);
        if (!f3[2] && v >= (m >> 1)) v = v - m;
        if (xlen == 32) return {32'd0, v[31:0]};
        return v[63:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_busy = 0;
        e_we = 0; e_err = 0; e_rd = 0; e_data = 0; e_ret = 0;
        e64_data = 0; e64_ret = 0;
    endtask

    // One cycle on the XLEN=32 instance. It is entered just after a rising edge.
    // It drives the inputs and checks the combinational outputs against the
    // model. It then advances the model and checks the registered outputs.
    task automatic applyStimulus(input bit v, input logic [4:0] rd, input bit we,
                                 input logic [1:0] src, input logic [2:0] f3,
                                 input logic [1:0] off, input logic [31:0] alu,
                                 input logic [31:0] pc, input bit rv,
                                 input logic [31:0] rdata);
        bit          done, c_we, c_err, c_write;
        logic [4:0]  c_rd;
        logic [31:0] c_val;
        logic [63:0] lv;
        valid_i = v; sel_rd_i = rd; rd_we_i = we; wb_src_i = src; load_funct3_i = f3;
        addr_off_i = off; alu_result_i = alu; pc_plus4_i = pc; mem_rvalid_i = rv;
        mem_rdata_i = rdata;
        #1;
        done = 0; c_we = 0; c_err = 0; c_rd = 0; c_val = 0;
        checkOutput("ready", ready_o, !m_busy);
        if (!m_busy) begin
            if (v && src == 2'd1 && !rv) begin
                m_busy = 1; m_rd = rd; m_we = we; m_f3 = f3; m_off = off;
            end else if (v) begin
                done = 1; c_rd = rd; c_we = we;
                if (src == 2'd1) begin
                    lv = refLoad(32, f3, int'(off), {32'd0, rdata}, c_err);
                    c_val = lv[31:0];
                end else begin
                    c_val = (src == 2'd2) ? pc : alu;
                end
            end
        end else if (rv) begin
            done = 1; c_rd = m_rd; c_we = m_we; m_busy = 0;
            lv = refLoad(32, m_f3, int'(m_off), {32'd0, rdata}, c_err);
            c_val = lv[31:0];
        end
        c_write = done && c_we && (c_rd != 5'd0) && !c_err;
        checkOutput("bypass_valid", bypass_valid_o, c_write);
        if (c_write) begin
            checkOutput("bypass_rd", bypass_rd_o, c_rd);
            checkOutput("bypass_data", bypass_data_o, c_val);
            e_rd = c_rd; e_data = c_val;
        end
        e_we  = c_write;
        e_err = done && c_err;
        if (done) e_ret = e_ret + 32'd1;
        @(posedge clk); #1;
        checkOutput("we_o", we_o, e_we);
        checkOutput("err_o", err_o, e_err);
        checkOutput("sel_rd_o", sel_rd_o, e_rd);
        checkOutput("data_o", data_o, e_data);
        checkOutput("retired_o", retired_o, e_ret);
    endtask

    // One load with a same-cycle response on the XLEN=64 instance
    task automatic applyStimulus64(input logic [2:0] f3, input logic [2:0] off,
                                   input logic [63:0] rdata);
        bit          c_err;
        logic [63:0] lv;
        d64_valid = 1; d64_sel_rd = 5'd10; d64_rd_we = 1; d64_wb_src = 2'd1;
        d64_f3 = f3; d64_off = off; d64_rvalid = 1; d64_rdata = rdata;
        lv = refLoad(64, f3, int'(off), rdata, c_err);
        if (!c_err) e64_data = lv;
        e64_ret = e64_ret + 32'd1;
        @(posedge clk); #1;
        d64_valid = 0; d64_rvalid = 0;
        checkOutput("d64_we_o", d64_we_o, !c_err);
        checkOutput("d64_err_o", d64_err_o, c_err);
        checkOutput("d64_data_o", d64_data_o, e64_data);
        checkOutput("d64_retired_o", d64_retired, e64_ret);
    endtask

    initial begin
        rst = 1;
        valid_i = 0; sel_rd_i = 0; rd_we_i = 0; wb_src_i = 0; load_funct3_i = 0;
        addr_off_i = 0; alu_result_i = 0; pc_plus4_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
        d64_valid = 0; d64_sel_rd = 0; d64_rd_we = 0; d64_wb_src = 0; d64_f3 = 0;
        d64_off = 0; d64_alu = 0; d64_pc = 0; d64_rvalid = 0; d64_rdata = 0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        $display("[TB] reset released");
        checkOutput("reset_ready", ready_o, 1'b1);
        checkOutput("reset_we", we_o, 1'b0);
        checkOutput("reset_data", data_o, 32'd0);
        checkOutput("reset_retired", retired_o, 32'd0);

        // ALU op to x5
        applyStimulus(1, 5'd5, 1, 2'd0, 3'd0, 2'd0, 32'h1234, 32'h0, 0, 32'h0);
        checkOutput("alu_data", data_o, 32'h1234);
        checkOutput("alu_retired", retired_o, 32'd1);

        // LB and LBU at offset 3 with a same-cycle response
        applyStimulus(1, 5'd6, 1, 2'd1, 3'd0, 2'd3, 32'h0, 32'h0, 1, 32'h80FF_FF00);
        checkOutput("lb_data", data_o, 32'hFFFF_FF80);
        applyStimulus(1, 5'd6, 1, 2'd1, 3'd4, 2'd3, 32'h0, 32'h0, 1, 32'h80FF_FF00);
        checkOutput("lbu_data", data_o, 32'h0000_0080);

        // LH to x7 whose response arrives three cycles late; an ALU op is
        // held valid behind it throughout the wait
        applyStimulus(1, 5'd7, 1, 2'd1, 3'd1, 2'd2, 32'h0, 32'h0, 0, 32'h0);
        applyStimulus(1, 5'd9, 1, 2'd0, 3'd0, 2'd0, 32'hAAAA, 32'h0, 0, 32'h0);
        applyStimulus(1, 5'd9, 1, 2'd0, 3'd0, 2'd0, 32'hAAAA, 32'h0, 0, 32'h0);
        applyStimulus(1, 5'd9, 1, 2'd0, 3'd0, 2'd0, 32'hAAAA, 32'h0, 1, 32'hBEEF_1234);
        checkOutput("lh_late_rd", sel_rd_o, 5'd7);
        checkOutput("lh_late_data", data_o, 32'hFFFF_BEEF);
        applyStimulus(1, 5'd9, 1, 2'd0, 3'd0, 2'd0, 32'hAAAA, 32'h0, 0, 32'h0);
        checkOutput("held_alu_data", data_o, 32'hAAAA);

        // Misaligned LW, then a PC+4 write to x0
        applyStimulus(1, 5'd4, 1, 2'd1, 3'd2, 2'd2, 32'h0, 32'h0, 1, 32'h1111_2222);
        checkOutput("lw_mis_err", err_o, 1'b1);
        applyStimulus(1, 5'd0, 1, 2'd2, 3'd0, 2'd0, 32'h0, 32'h0000_0404, 0, 32'h0);
        checkOutput("x0_data_held", data_o, 32'hAAAA);

        // Reset while a load is parked; the late response must be ignored
        applyStimulus(1, 5'd3, 1, 2'd1, 3'd2, 2'd0, 32'h0, 32'h0, 0, 32'h0);
        rst = 1;
        #2;
        modelReset();
        checkOutput("rst_wait_ready", ready_o, 1'b1);
        checkOutput("rst_wait_retired", retired_o, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        applyStimulus(0, 5'd3, 1, 2'd1, 3'd2, 2'd0, 32'h0, 32'h0, 1, 32'h5555_5555);
        checkOutput("rst_wait_no_write", we_o, 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 9) < 7,
                          ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                          $urandom_range(0, 5) != 0,
                          2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                          2'($urandom_range(0, 3)), $urandom, $urandom,
                          $urandom_range(0, 2) == 0, $urandom);
        end

        // XLEN=64 loads
        applyStimulus64(3'd6, 3'd4, 64'h8765_4321_0000_0000);
        checkOutput("lwu64_data", d64_data_o, 64'h0000_0000_8765_4321);
        applyStimulus64(3'd2, 3'd4, 64'h8765_4321_0000_0000);
        applyStimulus64(3'd3, 3'd0, 64'hFEDC_BA98_7654_3210);
        applyStimulus64(3'd3, 3'd4, 64'h0123_4567_89AB_CDEF);
        applyStimulus64(3'd1, 3'd6, 64'h8001_0000_0000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Parametrised successor to the single-cycle writeback stage.
- Selects the register-file write value from ALU result, load data, or PC+4.
- Performs load byte/half/word(/double) extraction with sign or zero extension.
- Tolerates variable-latency load responses with a one-deep wait state, suppresses x0 writes, flags misaligned loads, and provides a same-cycle forwarding bypass and a retire counter.
- Sits between the memory stage and the register file.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
NUM_REGS, 32, architectural register count; REG_AW = $clog2(NUM_REGS).
OFF_W, $clog2(XLEN/8), derived width of the load byte offset.

Ports:
clk  input  1  clock.
rst  input  1  asynchronous, active-high reset.
valid_i  input  1  upstream instruction valid.
ready_o  output  1  unit can accept this cycle.
sel_rd_i  input  REG_AW  destination register.
rd_we_i  input  1  instruction writes rd.
wb_src_i  input  2  0=ALU, 1=MEM, 2=PC+4, 3=ALU.
load_funct3_i  input  3  RISC-V load funct3.
addr_off_i  input  OFF_W  load address low bits.
alu_result_i  input  XLEN  ALU result.
pc_plus4_i  input  XLEN  PC+4 for jumps.
mem_rvalid_i  input  1  load response valid.
mem_rdata_i  input  XLEN  raw aligned memory word.
bypass_valid_o  output  1  combinational: a write commits next edge.
bypass_rd_o  output  REG_AW  combinational rd being written.
bypass_data_o  output  XLEN  combinational value being written.
sel_rd_o  output  REG_AW  registered rd.
we_o  output  1  registered write strobe.
data_o  output  XLEN  registered write data.
err_o  output  1  registered one-cycle misaligned/illegal-load pulse.
retired_o  output  32  count of completed instructions.

Behaviour:
- Reset (asynchronous, rst=1): FSM to IDLE; sel_rd_o=0, we_o=0, data_o=0, err_o=0, retired_o=0; pending load dropped.
- FSM states:
  - IDLE: ready_o=1.
  - WAIT_MEM: ready_o=0.
- Accept when valid_i && ready_o.
- Accept with wb_src!=1: completes in the accept cycle.
- Accept with wb_src==1 and mem_rvalid_i=1 in the same cycle: completes in the accept cycle.
- Accept with wb_src==1 and mem_rvalid_i=0: latch rd, rd_we, funct3 and offset; go to WAIT_MEM.
- WAIT_MEM: stays until mem_rvalid_i=1, then completes with the latched fields and returns to IDLE. ready_o=1 from the next cycle.
- mem_rvalid_i while IDLE with no MEM accept: ignored.
- Completion cycle:
  - write = rd_we && rd!=0 && !err.
  - bypass_valid_o = write; bypass_rd_o and bypass_data_o carry the commit values in the same cycle.
  - Next edge: we_o=write, sel_rd_o=rd, data_o=value, err_o=err, retired_o+1 (wraps at 2^32).
- Non-completion cycles: we_o=0, err_o=0, bypass_valid_o=0; sel_rd_o and data_o hold their last values.
- Latency: 1 cycle from accept for non-load and same-cycle-response loads; 1 cycle after mem_rvalid_i for delayed loads.
- Load extraction: shift = offset*8.
  - funct3 0 LB: sign-extend byte.
  - funct3 4 LBU: zero-extend byte.
  - funct3 1 LH: sign-extend half.
  - funct3 5 LHU: zero-extend half.
  - funct3 2 LW: sign-extend word to XLEN.
  - funct3 6 LWU: zero-extend word; XLEN=64 only.
  - funct3 3 LD: XLEN=64 only.
- Load err conditions:
  - offset not a multiple of the access size;
  - funct3 7;
  - funct3 3 or 6 when XLEN=32.
- On err, write is suppressed and err_o pulses; the instruction still retires.
- x0: any write to rd=0 is suppressed (we_o=0, bypass_valid_o=0) but retires.

Test Plan:
- ALU op, rd=5, alu=0x1234, valid 1 cycle -> next cycle we_o=1, sel_rd_o=5, data_o=0x1234, retired_o=1; bypass_data_o=0x1234 in the accept cycle.
- LB, off=3, rdata=0x80FF_FF00, rvalid same cycle -> data_o=0xFFFF_FF80 one cycle later; LBU same stimulus -> 0x0000_0080.
- LH, rd=7, rvalid 3 cycles late -> ready_o=0 for 3 cycles; we_o=1 the cycle after rvalid; an upstream valid held during the wait is accepted only after the return to IDLE.
- LW off=2 -> we_o=0, err_o=1 for one cycle, retired_o increments; PC+4 source with rd=0 -> we_o=0, data_o unchanged.
- rst asserted while in WAIT_MEM, then a late rvalid arrives -> IDLE, no write, retired_o=0.
- XLEN=64: LWU off=4, rdata=0x8765_4321_0000_0000 -> data_o=0x0000_0000_8765_4321.
